// File: rtl/parkimetro_pkg.sv
// Shared parkimetro constants: operating-mode codes and lane sensor state codes.
package parkimetro_pkg;

  localparam logic [1:0] ModoNormal = 2'b00;
  localparam logic [1:0] ModoLleno  = 2'b01;
  localparam logic [1:0] ModoFalla  = 2'b10;

  // Lane sensor sequence states (barrier A = outer loop, barrier B = inner loop)
  localparam logic [1:0] SensLibre    = 2'b00;
  localparam logic [1:0] SensBarreraA = 2'b01;
  localparam logic [1:0] SensAmbas    = 2'b11;
  localparam logic [1:0] SensBarreraB = 2'b10;

  function automatic logic modo_permite_entrada(input logic [1:0] modo);
    return modo == ModoNormal;
  endfunction

endpackage

// File: rtl/control_estacionamiento_if.sv
// Sensor-event and status bundle between the lane controllers and the parking counter.
interface control_estacionamiento_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned W       = 8
);

  logic [N_LANES-1:0] entra;
  logic [N_LANES-1:0] sale;
  logic [N_LANES-1:0] err_sensor;
  logic               err_clr;
  logic [W-1:0]       ocupados;
  logic [W-1:0]       libres;
  logic               lleno;
  logic               vacio;
  logic               semaforo;
  logic [N_LANES-1:0] err_lane;
  logic [1:0]         modo;

  modport master (
    output entra, sale, err_sensor, err_clr,
    input  ocupados, libres, lleno, vacio, semaforo, err_lane, modo
  );

  modport slave (
    input  entra, sale, err_sensor, err_clr,
    output ocupados, libres, lleno, vacio, semaforo, err_lane, modo
  );

endinterface

// File: rtl/rr_arbitro.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted lane.
module rr_arbitro #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] idx_p;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    idx_p = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx   = (32'(ptr_q) + off) % N;
      idx_p = PtrW'(idx);
      if (!found && req_i[idx_p]) begin
        found        = 1'b1;
        gnt_o[idx_p] = 1'b1;
        win          = idx_p;
      end
    end
  end

  // Explicit wrap keeps the pointer legal when N is not a power of two
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/control_estacionamiento.sv
// Parking occupancy counter: per-lane pending entry/exit events, round-robin service,
// sticky lane errors and NORMAL/LLENO/FALLA mode with entry traffic light.
module control_estacionamiento
  import parkimetro_pkg::*;
#(
  parameter int unsigned N_LANES   = 4,
  parameter int unsigned CAPACIDAD = 32,
  parameter int unsigned W         = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  control_estacionamiento_if.slave bus
);

  localparam logic [W-1:0] Cap = W'(CAPACIDAD);

  if (CAPACIDAD >= (64'd1 << W)) begin : g_cap_check
    $error("CAPACIDAD does not fit in W bits");
  end

  logic [N_LANES-1:0] pend_in_q, pend_in_d;
  logic [N_LANES-1:0] pend_out_q, pend_out_d;
  logic [N_LANES-1:0] req, gnt;
  logic [N_LANES-1:0] serve_in, serve_out;
  logic [N_LANES-1:0] pulse_err, cnt_err;
  logic [N_LANES-1:0] err_lane_q, err_lane_d;
  logic [W-1:0]       ocupados_q, ocupados_d;
  logic [W-1:0]       libres_q;
  logic               lleno_q, vacio_q, semaforo_q;
  logic               lleno_d;
  logic [1:0]         modo_q, modo_d;

  assign req = pend_in_q | pend_out_q;

  rr_arbitro #(
    .N (N_LANES)
  ) u_arbitro (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  // Exit has priority on a lane holding both events; entry waits for the next grant
  assign serve_out = gnt & pend_out_q;
  assign serve_in  = gnt & pend_in_q & ~pend_out_q;

  always_comb begin
    pend_in_d  = (pend_in_q & ~serve_in) | bus.entra;
    pend_out_d = (pend_out_q & ~serve_out) | bus.sale;
    pulse_err  = (bus.entra & pend_in_q & ~serve_in) | (bus.sale & pend_out_q & ~serve_out);
  end

  always_comb begin
    ocupados_d = ocupados_q;
    cnt_err    = '0;
    if (|serve_in) begin
      if (ocupados_q < Cap) begin
        ocupados_d = ocupados_q + W'(1);
      end else begin
        cnt_err = serve_in;
      end
    end else if (|serve_out) begin
      if (ocupados_q != '0) begin
        ocupados_d = ocupados_q - W'(1);
      end else begin
        cnt_err = serve_out;
      end
    end
  end

  // New errors and a live sensor fault override a simultaneous clear
  always_comb begin
    err_lane_d = (bus.err_clr ? '0 : err_lane_q) | pulse_err | cnt_err | bus.err_sensor;
  end

  assign lleno_d = (ocupados_d == Cap);

  always_comb begin
    modo_d = modo_q;
    case (modo_q)
      ModoNormal: begin
        if (|err_lane_d)  modo_d = ModoFalla;
        else if (lleno_d) modo_d = ModoLleno;
      end
      ModoLleno: begin
        if (|err_lane_d)   modo_d = ModoFalla;
        else if (!lleno_d) modo_d = ModoNormal;
      end
      ModoFalla: begin
        if (!(|err_lane_d)) modo_d = lleno_d ? ModoLleno : ModoNormal;
      end
      default: begin
        modo_d = (|err_lane_d) ? ModoFalla : (lleno_d ? ModoLleno : ModoNormal);
      end
    endcase
  end

  // Status flags are registered from next-state values so they track ocupados exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_in_q  <= '0;
      pend_out_q <= '0;
      err_lane_q <= '0;
      ocupados_q <= '0;
      libres_q   <= Cap;
      lleno_q    <= 1'b0;
      vacio_q    <= 1'b1;
      semaforo_q <= 1'b1;
      modo_q     <= ModoNormal;
    end else begin
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      err_lane_q <= err_lane_d;
      ocupados_q <= ocupados_d;
      libres_q   <= Cap - ocupados_d;
      lleno_q    <= lleno_d;
      vacio_q    <= (ocupados_d == '0);
      semaforo_q <= modo_permite_entrada(modo_d);
      modo_q     <= modo_d;
    end
  end

  assign bus.ocupados = ocupados_q;
  assign bus.libres   = libres_q;
  assign bus.lleno    = lleno_q;
  assign bus.vacio    = vacio_q;
  assign bus.semaforo = semaforo_q;
  assign bus.err_lane = err_lane_q;
  assign bus.modo     = modo_q;

endmodule

// File: doc/control_estacionamiento.md
CONTROL_ESTACIONAMIENTO -- requirements
Module: control_estacionamiento

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of sensor lanes (2..8).
REQ-002 SHALL have parameter CAPACIDAD, default 32, number of parking spaces (1..255).
REQ-003 SHALL have parameter W, default 8, counter width; CAPACIDAD SHALL fit in W bits.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port entra  input  N_LANES  one-cycle pulse per lane: a car completed entry.
REQ-007 SHALL have port sale  input  N_LANES  one-cycle pulse per lane: a car completed exit.
REQ-008 SHALL have port err_sensor  input  N_LANES  level per lane: lane sensor reports an invalid sequence.
REQ-009 SHALL have port err_clr  input  1  one-cycle pulse: clear the sticky error flags.
REQ-010 SHALL have port ocupados  output  W  registered count of occupied spaces.
REQ-011 SHALL have port libres  output  W  registered value CAPACIDAD - ocupados.
REQ-012 SHALL have port lleno, vacio  output  1 each  ocupados==CAPACIDAD, ocupados==0.
REQ-013 SHALL have port semaforo  output  1  entry permitted; 1 only in mode NORMAL.
REQ-014 SHALL have port err_lane  output  N_LANES  sticky per-lane error flags.
REQ-015 SHALL have port modo  output  2  mode code: NORMAL=00, LLENO=01, FALLA=10.

Function
REQ-016 SHALL capture each entra/sale pulse into a per-lane pending bit (pend_in, pend_out) on the cycle the pulse is high.
REQ-017 A pulse arriving while the matching pending bit is set and not being served that cycle SHALL set err_lane for that lane; the pulse is dropped.
REQ-018 A round-robin arbiter SHALL serve exactly one pending lane per cycle, starting after the last served lane; after reset the pointer starts at lane 0.
REQ-019 On a lane with both pend_in and pend_out set, pend_out SHALL be served first; pend_in is served on that lane's next grant.
REQ-020 Serving pend_in SHALL increment ocupados if ocupados<CAPACIDAD; otherwise ocupados holds and err_lane for that lane is set.
REQ-021 Serving pend_out SHALL decrement ocupados if ocupados>0; otherwise ocupados holds and err_lane for that lane is set.
REQ-022 A served pending bit SHALL clear in the same cycle that the counter updates; latency from pulse to ocupados change SHALL be 2 cycles when no other lane is pending.
REQ-023 A pulse arriving in the cycle its own pending bit is served SHALL re-set that bit (no error).
REQ-024 err_lane[i] SHALL also be set in every cycle that err_sensor[i] is 1.
REQ-025 err_clr SHALL clear all err_lane bits, except bits whose err_sensor or a new error is active that cycle (set wins).
REQ-026 Mode FSM: NORMAL->LLENO when ocupados reaches CAPACIDAD; LLENO->NORMAL when ocupados<CAPACIDAD.
REQ-027 Mode FSM: any state->FALLA when any err_lane bit is 1; FALLA->NORMAL or LLENO (per lleno) when all err_lane are 0.
REQ-028 Counting SHALL continue in FALLA mode; only semaforo is affected.
REQ-029 modo, semaforo, lleno, vacio and libres SHALL be registered and reflect ocupados with no additional latency relative to ocupados.

Reset
REQ-030 While rst_n=0: ocupados=0, libres=CAPACIDAD, vacio=1, lleno=0, modo=NORMAL, semaforo=1, err_lane=0, all pending bits=0, arbiter pointer=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending events immediately (asynchronously); the first clock edge after release SHALL capture new pulses normally.

Structure
REQ-032 The mode encodings (NORMAL, LLENO, FALLA) SHALL be defined as localparams in the shared parkimetro constants package, alongside the sensor state codes.
REQ-033 The round-robin arbiter SHALL be a sub-module named rr_arbitro (request vector in, one-hot grant out, pointer update on grant).

Verification
REQ-034 Reset, then entra[0] pulse -> ocupados=1, libres=31, vacio=0 two cycles later.
REQ-035 entra=4'b1111 in one cycle -> ocupados steps 1,2,3,4 on consecutive cycles, lanes served in order 0,1,2,3.
REQ-036 CAPACIDAD=32, fill to 32 -> lleno=1, modo=LLENO, semaforo=0; a further entra[2] -> ocupados stays 32 and err_lane[2]=1.
REQ-037 ocupados=0, sale[1] -> ocupados stays 0, err_lane[1]=1, modo=FALLA; err_clr -> modo=NORMAL the next cycle.
REQ-038 err_sensor[3] held high with err_clr pulsed -> err_lane[3] stays 1, modo stays FALLA.
REQ-039 Pending events on lanes 0 and 2, rst_n pulsed low -> ocupados=0, pending bits cleared, no count change after release.
